// File: rtl/mmt_pkg.sv
// Shared types and sizing helpers for the NxN torus matrix multiplier.
package mmt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MAC,
    DONE
  } state_e;

  // Result width that cannot overflow for an N-term dot product of W-bit operands.
  function automatic int unsigned cw_of(input int unsigned n, input int unsigned w);
    return 2 * w + int'($clog2(n));
  endfunction

  // Step-counter width; k runs 0..N-1.
  function automatic int unsigned kw_of(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/torus_pe.sv
// One torus processing element: a/b operand registers plus a CW-bit multiply-accumulate.
module torus_pe #(
  parameter int unsigned W      = 4,
  parameter int unsigned CW     = 9,
  parameter bit          SIGNED = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          shift,
  input  logic [W-1:0]  a_ld,
  input  logic [W-1:0]  b_ld,
  input  logic [W-1:0]  a_nb,
  input  logic [W-1:0]  b_nb,
  output logic [W-1:0]  a,
  output logic [W-1:0]  b,
  output logic [CW-1:0] acc_nxt_c
);

  logic [CW-1:0]  acc;
  logic [2*W-1:0] a_x;
  logic [2*W-1:0] b_x;
  logic [2*W-1:0] prod;

  // Extend operands to 2W first so the low 2W bits of the product are exact in either mode.
  if (SIGNED) begin : g_signed
    assign a_x = {{W{a[W-1]}}, a};
    assign b_x = {{W{b[W-1]}}, b};
  end else begin : g_unsigned
    assign a_x = {{W{1'b0}}, a};
    assign b_x = {{W{1'b0}}, b};
  end

  assign prod      = a_x * b_x;
  assign acc_nxt_c = acc + {{(CW-2*W){SIGNED & prod[2*W-1]}}, prod};

  always_ff @(posedge clk) begin
    if (rst) begin
      a   <= '0;
      b   <= '0;
      acc <= '0;
    end else if (load) begin
      a   <= a_ld;
      b   <= b_ld;
      acc <= '0;
    end else if (shift) begin
      a   <= a_nb;
      b   <= b_nb;
      acc <= acc_nxt_c;
    end
  end

endmodule

// File: rtl/matrix_mult_torus_nxn.sv
// NxN matrix multiplier C = A x B using Cannon's algorithm on an N x N torus of PEs.
module matrix_mult_torus_nxn
  import mmt_pkg::*;
#(
  parameter int unsigned N      = 2,
  parameter int unsigned W      = 4,
  parameter bit          SIGNED = 1'b0,
  parameter int unsigned CW     = cw_of(N, W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stm,
  input  logic [N*N*W-1:0]  a_flat,
  input  logic [N*N*W-1:0]  b_flat,
  output logic [N*N*CW-1:0] c_flat,
  output logic              busy,
  output logic              eom
);

  localparam int unsigned KW = kw_of(N);

  state_e        state;
  logic [KW-1:0] k;
  logic          load;
  logic          shift;
  logic          last;

  logic [W-1:0]  a_q     [N][N];
  logic [W-1:0]  b_q     [N][N];
  logic [CW-1:0] acc_nxt [N][N];

  assign load  = (state == LOAD);
  assign shift = (state == MAC);
  assign last  = shift && (k == KW'(N-1));

  // PE grid: skewed load sources and mod-N neighbour links close the torus.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      localparam int unsigned JA = (j + i) % N;
      localparam int unsigned IB = (i + j) % N;
      localparam int unsigned JR = (j + 1) % N;
      localparam int unsigned IR = (i + 1) % N;

      torus_pe #(
        .W      (W),
        .CW     (CW),
        .SIGNED (SIGNED)
      ) u_pe (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .a_ld      (a_flat[(i*N+JA)*W +: W]),
        .b_ld      (b_flat[(IB*N+j)*W +: W]),
        .a_nb      (a_q[i][JR]),
        .b_nb      (b_q[IR][j]),
        .a         (a_q[i][j]),
        .b         (b_q[i][j]),
        .acc_nxt_c (acc_nxt[i][j])
      );
    end
  end

  // Control FSM; busy/eom are set on the same edge as the state so they are pure registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      busy  <= 1'b0;
      eom   <= 1'b0;
    end else begin
      eom <= 1'b0;
      case (state)
        IDLE: begin
          if (stm) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          state <= MAC;
          k     <= '0;
        end
        MAC: begin
          if (k == KW'(N-1)) begin
            state <= DONE;
            eom   <= 1'b1;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Capture the final accumulations on the edge entering DONE so c_flat and eom appear together.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_flat <= '0;
    end else if (last) begin
      for (int ii = 0; ii < N; ii++) begin
        for (int jj = 0; jj < N; jj++) begin
          c_flat[(ii*N+jj)*CW +: CW] <= acc_nxt[ii][jj];
        end
      end
    end
  end

endmodule
